// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and sizing constants shared by the HI/LO
// multiply/divide controller and its divide datapath.
package mdu_pkg;

  localparam int DIV_ITER    = 32;
  localparam int MUL_LAT_DEF = 2;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Magnitude of a 32-bit value, treating it as two's complement only when sgn is set.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// div_iter: radix-2 restoring divider on unsigned magnitudes, one quotient bit
// per cycle for DIV_ITER cycles after start. quotient/remainder present the
// result of the current step, so they hold the final answer while done is high.
module div_iter
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int CW = $clog2(DIV_ITER);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [31:0]   rem_q;
  logic [31:0]   quo_q;
  logic [31:0]   dsr_q;
  logic [32:0]   shifted;
  logic          fits;

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  always_comb begin
    shifted   = {rem_q, quo_q[31]};
    fits      = (shifted >= {1'b0, dsr_q});
    quotient  = {quo_q[30:0], fits};
    remainder = fits ? (shifted[31:0] - dsr_q) : shifted[31:0];
    done      = busy && (cnt == CW'(DIV_ITER - 1));
  end

  // Iteration registers: load on start, step while busy, drop out on abort.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy  <= 1'b0;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (busy) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt   <= cnt + CW'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO unit controller. Multiplies run through a MUL_LAT-deep
// product pipeline, divides through div_iter, MTHI/MTLO complete directly.
// Results land in registered hi_o/lo_o and are strobed by a one-cycle hilo_we.
// Build macro MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (accumulate into HI/LO);
// without it those op codes are ignored.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        flush,
  output logic        stall_o,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int PIPE_N = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  state_e      state;
  state_e      state_nxt;
  logic        dec_mul;
  logic        dec_div;
  logic        dec_mt;
  logic        dec_signed;
  logic        accept;
  logic        div_start;
  logic        div_done;
  logic        mul_last;
  logic [2:0]  mul_cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sgn_q;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] mul_comb;
  logic [63:0] mul_res;
  logic [63:0] mul_final;
  logic [63:0] mul_pipe [PIPE_N];
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
`ifdef MDU_MADD_EN
  logic        dec_add;
  logic        dec_sub;
  logic        add_q;
  logic        sub_q;
  logic [63:0] acc_q;
`endif

  // Classify the incoming op code into multiply / divide / move-to classes.
  always_comb begin
    dec_mul    = 1'b0;
    dec_div    = 1'b0;
    dec_mt     = 1'b0;
    dec_signed = 1'b0;
`ifdef MDU_MADD_EN
    dec_add    = 1'b0;
    dec_sub    = 1'b0;
`endif
    case (op)
      OP_MULT:  begin dec_mul = 1'b1; dec_signed = 1'b1; end
      OP_MULTU: dec_mul = 1'b1;
      OP_DIV:   begin dec_div = 1'b1; dec_signed = 1'b1; end
      OP_DIVU:  dec_div = 1'b1;
      OP_MTHI:  dec_mt = 1'b1;
      OP_MTLO:  dec_mt = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin dec_mul = 1'b1; dec_signed = 1'b1; dec_add = 1'b1; end
      OP_MADDU: begin dec_mul = 1'b1; dec_add = 1'b1; end
      OP_MSUB:  begin dec_mul = 1'b1; dec_signed = 1'b1; dec_sub = 1'b1; end
      OP_MSUBU: begin dec_mul = 1'b1; dec_sub = 1'b1; end
`endif
      default:  ;
    endcase
  end

  assign accept   = (state == ST_IDLE) && op_valid && !flush && (dec_mul || dec_div || dec_mt);
  assign mul_last = (state == ST_MUL) && (mul_cnt == 3'(MUL_LAT - 1));

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides everything and returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_nxt = dec_mul ? ST_MUL : (dec_div ? ST_DIV : ST_DONE);
        ST_MUL:  if (mul_last) state_nxt = ST_DONE;
        ST_DIV:  if (div_done) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs: stall from acceptance of a long op until its result is ready.
  always_comb begin
    stall_o   = ((state == ST_IDLE) && accept && (dec_mul || dec_div)) ||
                (state == ST_MUL) || (state == ST_DIV);
    hilo_we   = (state == ST_DONE) && !flush;
    div_start = accept && dec_div;
  end

  // Operand extension and the inferred 64-bit product of the latched operands.
  always_comb begin
    ext_a    = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    ext_b    = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    mul_comb = ext_a * ext_b;
  end

  // Product pipeline so the product is retimed across MUL_LAT cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < PIPE_N; i++) mul_pipe[i] <= '0;
    end else begin
      mul_pipe[0] <= mul_comb;
      for (int i = 1; i < PIPE_N; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
  end

  assign mul_res = (MUL_LAT == 1) ? mul_comb : mul_pipe[PIPE_N-1];

  // Final multiply result, optionally accumulated into the latched HI/LO.
  always_comb begin
`ifdef MDU_MADD_EN
    if (add_q)      mul_final = acc_q + mul_res;
    else if (sub_q) mul_final = acc_q - mul_res;
    else            mul_final = mul_res;
`else
    mul_final = mul_res;
`endif
  end

  assign div_dividend = abs32(src_a, dec_signed);
  assign div_divisor  = abs32(src_b, dec_signed);

  div_iter u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .abort     (flush),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Sign restoration for signed divide; divide by zero has a fixed answer.
  always_comb begin
    quo_fix = (sgn_q && (a_q[31] ^ b_q[31])) ? (~div_q + 32'd1) : div_q;
    rem_fix = (sgn_q && a_q[31]) ? (~div_r + 32'd1) : div_r;
    if (b_q == '0) begin
      quo_fix = '1;
      rem_fix = a_q;
    end
  end

  // Operand latching at acceptance and result capture into hi_o/lo_o.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      mul_cnt <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
`ifdef MDU_MADD_EN
      acc_q   <= '0;
      add_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_q     <= src_a;
        b_q     <= src_b;
        sgn_q   <= dec_signed;
        mul_cnt <= '0;
`ifdef MDU_MADD_EN
        acc_q   <= {hi_i, lo_i};
        add_q   <= dec_add;
        sub_q   <= dec_sub;
`endif
        if (dec_mt) begin
          hi_o <= (op == OP_MTHI) ? src_a : hi_i;
          lo_o <= (op == OP_MTLO) ? src_a : lo_i;
        end
      end
      if ((state == ST_MUL) && !flush) begin
        mul_cnt <= mul_cnt + 3'd1;
        if (mul_last) begin
          {hi_o, lo_o} <= mul_final;
        end
      end
      if ((state == ST_DIV) && div_done && !flush) begin
        hi_o <= rem_fix;
        lo_o <= quo_fix;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and randomized checks of mdu_ctrl against an
// arithmetic reference model (64-bit products, integer / and %).
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        op_valid = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [31:0] hi_i = '0;
  logic [31:0] lo_i = '0;
  logic        flush = 1'b0;
  logic        stall_o;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_ctrl #(.MUL_LAT(LAT)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .hi_i     (hi_i),
    .lo_i     (lo_i),
    .flush    (flush),
    .stall_o  (stall_o),
    .hilo_we  (hilo_we),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Safety net in case the design never lets the sequence progress.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: what the op should produce and how many cycles it takes.
  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l,
                                output bit acc, output int lat,
                                output logic [31:0] eh, output logic [31:0] el);
    longint      sa, sb, q, r;
    logic [63:0] p, res;
    bit          madd_en;
`ifdef MDU_MADD_EN
    madd_en = 1'b1;
`else
    madd_en = 1'b0;
`endif
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = 1'b1;
    lat = LAT + 1;
    res = '0;
    case (o)
      4'd0: res = sa * sb;
      4'd1: res = {32'd0, a} * {32'd0, b};
      4'd2, 4'd3: begin
        lat = 33;
        if (b == 32'd0) begin
          res = {a, 32'hFFFFFFFF};
        end else if (o == 4'd2) begin
          q = sa / sb;
          r = sa % sb;
          res = {32'(r), 32'(q)};
        end else begin
          res = {a % b, a / b};
        end
      end
      4'd4: begin lat = 1; res = {a, l}; end
      4'd5: begin lat = 1; res = {h, a}; end
      4'd6, 4'd7, 4'd8, 4'd9: begin
        acc = madd_en;
        p   = (o == 4'd6 || o == 4'd8) ? 64'(sa * sb) : ({32'd0, a} * {32'd0, b});
        res = (o <= 4'd7) ? ({h, l} + p) : ({h, l} - p);
      end
      default: acc = 1'b0;
    endcase
    eh = res[63:32];
    el = res[31:0];
  endfunction

  // Issue one op at a negedge, then verify stall count, latency, result and
  // the single-cycle strobe; returns at a negedge with the unit idle.
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] h, input logic [31:0] l, input string tag);
    bit          acc;
    int          lat, k, stalls, pulses;
    logic [31:0] eh, el;
    model(o, a, b, h, l, acc, lat, eh, el);
    op = o; src_a = a; src_b = b; hi_i = h; lo_i = l; op_valid = 1'b1;
    #1;
    stalls = stall_o ? 1 : 0;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    src_a = $urandom; src_b = $urandom; hi_i = $urandom; lo_i = $urandom;
    op = 4'($urandom_range(0, 15));
    if (acc) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
        if (stall_o) stalls++;
      end while (!hilo_we && k < 60);
      check({tag, "_latency"}, 64'(k), 64'(lat));
      check({tag, "_stalls"}, 64'(stalls), (lat > 1) ? 64'(lat) : 64'd0);
      check({tag, "_result"}, {hi_o, lo_o}, {eh, el});
      @(negedge clk);
      check({tag, "_we_pulse"}, 64'(hilo_we), 64'd0);
    end else begin
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (hilo_we) pulses++;
        if (stall_o) stalls++;
      end
      check({tag, "_ignored_we"}, 64'(pulses), 64'd0);
      check({tag, "_ignored_stall"}, 64'(stalls), 64'd0);
    end
  endtask

  // Watch a window of cycles expecting the unit to stay quiet.
  task automatic checkOutput(input string tag, input int cycles);
    int pulses, stalls;
    pulses = 0;
    stalls = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (hilo_we) pulses++;
      if (stall_o) stalls++;
    end
    check({tag, "_no_we"}, 64'(pulses), 64'd0);
    check({tag, "_no_stall"}, 64'(stalls), 64'd0);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;

    // Reset values.
    #12;
    check("reset_stall", 64'(stall_o), 64'd0);
    check("reset_we", 64'(hilo_we), 64'd0);
    check("reset_hilo", {hi_o, lo_o}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Directed cases from the datasheet examples.
    applyStimulus(4'd0, 32'hFFFFFFFD, 32'd7, 32'd0, 32'd0, "mult_m3x7");
    applyStimulus(4'd2, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, "div_m7d2");
    applyStimulus(4'd3, 32'd7, 32'd0, 32'd0, 32'd0, "divu_7d0");
    applyStimulus(4'd4, 32'h12345678, 32'd0, 32'd0, 32'd5, "mthi");
    applyStimulus(4'd5, 32'hCAFEF00D, 32'd0, 32'hA5A5A5A5, 32'd9, "mtlo");
    applyStimulus(4'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, "div_ovf");
    applyStimulus(4'd2, 32'hFFFFFFF9, 32'd0, 32'd0, 32'd0, "div_m7d0");
    applyStimulus(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, "multu_max");
    applyStimulus(4'd7, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, "maddu_1x1");
    applyStimulus(4'd8, 32'd3, 32'hFFFFFFFE, 32'd0, 32'd10, "msub");
    applyStimulus(4'hC, 32'd1, 32'd1, 32'd0, 32'd0, "undef_op");

    // Flush in the accept cycle suppresses the op.
    op = 4'd3; src_a = 32'd100; src_b = 32'd3; op_valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_accept_stall", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1;
    op_valid = 1'b0; flush = 1'b0;
    checkOutput("flush_accept", 40);

    // Flush on DIV cycle 10 aborts the divide.
    op = 4'd3; src_a = 32'd1000; src_b = 32'd7; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_div_stall", 64'(stall_o), 64'd0);
    checkOutput("flush_div", 40);

    // Flush during DONE kills the strobe.
    op = 4'd4; src_a = 32'h55; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_done_we", 64'(hilo_we), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_done", 5);

    // Operation resumes normally after the aborted ops.
    applyStimulus(4'd3, 32'd1000, 32'd7, 32'd0, 32'd0, "divu_after_flush");

    // Reset in the middle of a divide.
    op = 4'd2; src_a = 32'h7FFF0000; src_b = 32'd13; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst_mid_stall", 64'(stall_o), 64'd0);
    check("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    checkOutput("rst_mid", 40);

    // Randomized ops, biased toward divide corner cases.
    for (int i = 0; i < 30; i++) begin
      ro = 4'($urandom_range(0, 9));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      applyStimulus(ro, ra, rb, $urandom, $urandom, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
